// File: rtl/merge_sink.sv
// Root-port receiver for the merge network: strips head flits, tags payload with source/SOP/EOP,
// buffers it in a first-word-fallthrough FIFO. Define MERGE_SINK_CHECK_EN for length/framing checks.
module merge_sink #(
  parameter int unsigned DW    = 32,
  parameter int unsigned SRC_W = 4,
  parameter int unsigned LEN_W = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_i,
  input  logic [DW-1:0]     data_i,
  output logic              ready_o,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DW-3:0]     out_data,
  output logic [SRC_W-1:0]  out_src,
  output logic              out_sop,
  output logic              out_eop,
  output logic [15:0]       pkt_cnt,
  output logic [7:0]        err_cnt
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned EW = SRC_W + 2 + DW - 2;

  localparam logic [1:0] TyBody = 2'b00;
  localparam logic [1:0] TyHead = 2'b01;
  localparam logic [1:0] TyTail = 2'b10;

  typedef enum logic [0:0] {StIdle, StPayload} state_e;

  state_e             state_q, state_d;
  logic [SRC_W-1:0]   src_q, src_d;
  logic               first_q, first_d;
  logic [15:0]        pkt_q;
  logic [AW-1:0]      wptr_q, rptr_q;
  logic [AW:0]        cnt_q;
  logic [EW-1:0]      mem_q [DEPTH];

  logic [1:0]         ftype;
  logic [LEN_W-1:0]   len;
  logic               accept, full, empty, push, pop, err, pkt_inc, wr_eop;
  logic [EW-1:0]      rd_entry;

  assign ftype  = data_i[DW-1:DW-2];
  assign len    = data_i[LEN_W-1:0];
  assign full   = (cnt_q == (AW+1)'(DEPTH));
  assign empty  = (cnt_q == '0);
  assign ready_o = !rst && !full;
  assign accept = valid_i && ready_o;
  assign pop    = !empty && out_ready;

`ifdef MERGE_SINK_CHECK_EN
  logic [LEN_W-1:0] rem_q, rem_d;
  logic [7:0]       err_q;
`endif

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    first_d = first_q;
    push    = 1'b0;
    err     = 1'b0;
    pkt_inc = 1'b0;
    wr_eop  = 1'b0;
`ifdef MERGE_SINK_CHECK_EN
    rem_d   = rem_q;
`endif
    if (accept) begin
      if (ftype == TyHead) begin
        // A head inside a packet truncates it; the new head is then parsed as from idle.
        if (state_q == StPayload) err = 1'b1;
`ifdef MERGE_SINK_CHECK_EN
        if (len == '0) begin
          err     = 1'b1;
          state_d = StIdle;
        end else begin
          src_d   = data_i[DW-3 -: SRC_W];
          rem_d   = len;
          first_d = 1'b1;
          state_d = StPayload;
        end
`else
        src_d   = data_i[DW-3 -: SRC_W];
        first_d = 1'b1;
        state_d = StPayload;
`endif
      end else if (state_q == StIdle || !(ftype == TyBody || ftype == TyTail)) begin
        err = 1'b1;
      end else begin
        push    = 1'b1;
        first_d = 1'b0;
        if (ftype == TyTail) begin
          wr_eop  = 1'b1;
          pkt_inc = 1'b1;
          state_d = StIdle;
`ifdef MERGE_SINK_CHECK_EN
          if (rem_q != LEN_W'(1)) err = 1'b1;
          rem_d = '0;
`endif
        end else begin
`ifdef MERGE_SINK_CHECK_EN
          if (rem_q == LEN_W'(1)) err = 1'b1;
          if (rem_q != '0) rem_d = rem_q - LEN_W'(1);
`endif
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      src_q   <= '0;
      first_q <= 1'b0;
      pkt_q   <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
`ifdef MERGE_SINK_CHECK_EN
      rem_q   <= '0;
      err_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      first_q <= first_d;
      if (pkt_inc) pkt_q <= pkt_q + 16'd1;
      if (push) wptr_q <= wptr_q + AW'(1);
      if (pop) rptr_q <= rptr_q + AW'(1);
      if (push && !pop) begin
        cnt_q <= cnt_q + (AW+1)'(1);
      end else if (pop && !push) begin
        cnt_q <= cnt_q - (AW+1)'(1);
      end
`ifdef MERGE_SINK_CHECK_EN
      rem_q <= rem_d;
      if (err && err_q != 8'hFF) err_q <= err_q + 8'd1;
`endif
    end
  end

  // Storage needs no reset: entries are only observable while the count says they are valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= {src_q, first_q, wr_eop, data_i[DW-3:0]};
  end

  assign rd_entry  = mem_q[rptr_q];
  assign out_valid = !empty;
  assign out_src   = out_valid ? rd_entry[EW-1 -: SRC_W] : '0;
  assign out_sop   = out_valid ? rd_entry[DW-1] : 1'b0;
  assign out_eop   = out_valid ? rd_entry[DW-2] : 1'b0;
  assign out_data  = out_valid ? rd_entry[DW-3:0] : '0;
  assign pkt_cnt   = pkt_q;

`ifdef MERGE_SINK_CHECK_EN
  assign err_cnt = err_q;
`else
  logic unused_err;
  assign unused_err = err;
  assign err_cnt    = '0;
`endif

endmodule

// File: tb/tb_merge_sink.sv
// Directed bench for merge_sink; expected error counts follow MERGE_SINK_CHECK_EN.
module tb_merge_sink;

`ifdef MERGE_SINK_CHECK_EN
  localparam int ChkEn = 1;
`else
  localparam int ChkEn = 0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid_i = 1'b0;
  logic [31:0] data_i = '0;
  logic        ready_o, out_valid, out_sop, out_eop;
  logic        out_ready = 1'b0;
  logic [29:0] out_data;
  logic [3:0]  out_src;
  logic [15:0] pkt_cnt;
  logic [7:0]  err_cnt;

  int nvec = 0;
  int nmis = 0;
  logic [35:0] cap[$];

  always #5 clk = ~clk;

  merge_sink #(.DW(32), .SRC_W(4), .LEN_W(8), .DEPTH(8)) dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .data_i(data_i), .ready_o(ready_o),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_src(out_src),
    .out_sop(out_sop), .out_eop(out_eop), .pkt_cnt(pkt_cnt), .err_cnt(err_cnt)
  );

  always @(posedge clk) begin
    if (!rst && out_valid && out_ready) cap.push_back({out_src, out_sop, out_eop, out_data});
  end

  function automatic logic [31:0] head(input logic [3:0] src, input logic [7:0] len);
    return {2'b01, src, 18'd0, len};
  endfunction
  function automatic logic [31:0] body(input logic [29:0] p);
    return {2'b00, p};
  endfunction
  function automatic logic [31:0] tail(input logic [29:0] p);
    return {2'b10, p};
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    valid_i = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    cap.delete();
  endtask

  task automatic send(input logic [31:0] f);
    int n = 0;
    valid_i = 1'b1;
    data_i  = f;
    while (!ready_o && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!ready_o) begin
      nvec++; nmis++;
      $display("FAIL send_timeout: ready_o got 0 want 1 for flit %h", f);
    end else begin
      @(posedge clk); #1;
    end
    valid_i = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (out_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    nvec++;
    if (out_valid !== 1'b0) begin
      nmis++; $display("FAIL drain: out_valid got %b want 0", out_valid);
    end
  endtask

  task automatic check_cap(input int idx, input logic [35:0] exp);
    nvec++;
    if (idx >= cap.size()) begin
      nmis++; $display("FAIL cap_missing[%0d]: got none want %h", idx, exp);
    end else if (cap[idx] !== exp) begin
      nmis++; $display("FAIL cap[%0d]: got %h want %h", idx, cap[idx], exp);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    nvec++; if (ready_o !== 1'b0) begin nmis++; $display("FAIL rst_ready: got %b want 0", ready_o); end
    nvec++; if (out_valid !== 1'b0) begin nmis++; $display("FAIL rst_valid: got %b want 0", out_valid); end
    nvec++; if ({out_data, out_src, out_sop, out_eop} !== 36'd0) begin
      nmis++; $display("FAIL rst_fields: got %h want 0", {out_data, out_src, out_sop, out_eop});
    end
    nvec++; if (pkt_cnt !== 16'd0 || err_cnt !== 8'd0) begin
      nmis++; $display("FAIL rst_cnt: got %0d/%0d want 0/0", pkt_cnt, err_cnt);
    end
    rst = 1'b0;
    #1;
    nvec++; if (ready_o !== 1'b1) begin nmis++; $display("FAIL rst_release_ready: got %b want 1", ready_o); end
  endtask

  task automatic test_basic();
    logic [29:0] pl [3];
    pl[0] = 30'h11; pl[1] = 30'h22; pl[2] = 30'h33;
    do_reset();
    out_ready = 1'b1;
    send(head(4'd3, 8'd3));
    nvec++; if (out_valid !== 1'b0) begin nmis++; $display("FAIL basic_head_pushed: got %b want 0", out_valid); end
    for (int i = 0; i < 3; i++) begin
      send(i == 2 ? tail(pl[i]) : body(pl[i]));
      nvec++;
      if ({out_valid, out_src, out_sop, out_eop, out_data} !== {1'b1, 4'd3, i == 0, i == 2, pl[i]}) begin
        nmis++;
        $display("FAIL basic_out[%0d]: got v=%b src=%0d sop=%b eop=%b d=%h want v=1 src=3 sop=%b eop=%b d=%h",
                 i, out_valid, out_src, out_sop, out_eop, out_data, i == 0, i == 2, pl[i]);
      end
    end
    nvec++; if (pkt_cnt !== 16'd1) begin nmis++; $display("FAIL basic_pkt: got %0d want 1", pkt_cnt); end
    nvec++; if (err_cnt !== 8'd0) begin nmis++; $display("FAIL basic_err: got %0d want 0", err_cnt); end
    drain();
  endtask

  task automatic test_backpressure();
    do_reset();
    out_ready = 1'b0;
    send(head(4'd5, 8'd5));
    for (int i = 0; i < 4; i++) send(body(30'h100 + 30'(i)));
    send(tail(30'h104));
    send(head(4'd6, 8'd5));
    for (int i = 0; i < 3; i++) send(body(30'h200 + 30'(i)));
    nvec++; if (ready_o !== 1'b0) begin nmis++; $display("FAIL bp_full_ready: got %b want 0", ready_o); end
    nvec++; if ({out_valid, out_sop, out_data} !== {1'b1, 1'b1, 30'h100}) begin
      nmis++; $display("FAIL bp_head: got v=%b sop=%b d=%h want 1 1 100", out_valid, out_sop, out_data);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    nvec++; if (ready_o !== 1'b1) begin nmis++; $display("FAIL bp_reassert: got %b want 1", ready_o); end
    out_ready = 1'b1;
    send(body(30'h203));
    send(tail(30'h204));
    drain();
    nvec++; if (cap.size() != 10) begin nmis++; $display("FAIL bp_count: got %0d want 10", cap.size()); end
    for (int i = 0; i < 5; i++) begin
      check_cap(i, {4'd5, i == 0, i == 4, 30'h100 + 30'(i)});
      check_cap(i + 5, {4'd6, i == 0, i == 4, 30'h200 + 30'(i)});
    end
    nvec++; if (pkt_cnt !== 16'd2) begin nmis++; $display("FAIL bp_pkt: got %0d want 2", pkt_cnt); end
  endtask

  task automatic test_framing();
    do_reset();
    out_ready = 1'b1;
    send(body(30'h1));
    send({2'b11, 30'h2});
    send(head(4'd9, 8'd0));
    nvec++; if (err_cnt !== 8'(3 * ChkEn)) begin
      nmis++; $display("FAIL frame_err: got %0d want %0d", err_cnt, 3 * ChkEn);
    end
    nvec++; if (cap.size() != 0 || out_valid !== 1'b0) begin
      nmis++; $display("FAIL frame_push: got %0d entries want 0", cap.size());
    end
    nvec++; if (pkt_cnt !== 16'd0) begin nmis++; $display("FAIL frame_pkt: got %0d want 0", pkt_cnt); end
  endtask

  task automatic test_truncation();
    do_reset();
    out_ready = 1'b1;
    send(head(4'd1, 8'd4));
    send(body(30'hA));
    send(head(4'd2, 8'd1));
    send(tail(30'hB));
    drain();
    nvec++; if (cap.size() != 2) begin nmis++; $display("FAIL trunc_count: got %0d want 2", cap.size()); end
    check_cap(0, {4'd1, 1'b1, 1'b0, 30'hA});
    check_cap(1, {4'd2, 1'b1, 1'b1, 30'hB});
    nvec++; if (err_cnt !== 8'(ChkEn)) begin nmis++; $display("FAIL trunc_err: got %0d want %0d", err_cnt, ChkEn); end
    nvec++; if (pkt_cnt !== 16'd1) begin nmis++; $display("FAIL trunc_pkt: got %0d want 1", pkt_cnt); end
  endtask

  task automatic test_length();
    do_reset();
    out_ready = 1'b1;
    send(head(4'd3, 8'd3));
    send(tail(30'h5));
    nvec++; if (err_cnt !== 8'(ChkEn)) begin nmis++; $display("FAIL len_short_err: got %0d want %0d", err_cnt, ChkEn); end
    nvec++; if (pkt_cnt !== 16'd1) begin nmis++; $display("FAIL len_short_pkt: got %0d want 1", pkt_cnt); end
    // Body where only the tail remains, then a tail with nothing left: two offending flits.
    send(head(4'd4, 8'd1));
    send(body(30'h6));
    send(tail(30'h7));
    drain();
    nvec++; if (err_cnt !== 8'(3 * ChkEn)) begin
      nmis++; $display("FAIL len_long_err: got %0d want %0d", err_cnt, 3 * ChkEn);
    end
    check_cap(1, {4'd4, 1'b1, 1'b0, 30'h6});
    check_cap(2, {4'd4, 1'b0, 1'b1, 30'h7});
    nvec++; if (pkt_cnt !== 16'd2) begin nmis++; $display("FAIL len_long_pkt: got %0d want 2", pkt_cnt); end
  endtask

  task automatic test_reset_mid_packet();
    do_reset();
    out_ready = 1'b0;
    send(head(4'd7, 8'd3));
    send(body(30'h1));
    nvec++; if (out_valid !== 1'b1) begin nmis++; $display("FAIL midrst_pre: got %b want 1", out_valid); end
    rst = 1'b1;
    #1;
    nvec++; if (ready_o !== 1'b0) begin nmis++; $display("FAIL midrst_ready: got %b want 0", ready_o); end
    @(posedge clk); #1;
    rst = 1'b0;
    nvec++; if ({out_valid, out_data, out_src, out_sop, out_eop} !== 37'd0) begin
      nmis++; $display("FAIL midrst_out: got %h want 0", {out_valid, out_data, out_src, out_sop, out_eop});
    end
    send(tail(30'h2));
    nvec++; if (out_valid !== 1'b0) begin nmis++; $display("FAIL midrst_tail_push: got %b want 0", out_valid); end
    nvec++; if (err_cnt !== 8'(ChkEn)) begin nmis++; $display("FAIL midrst_err: got %0d want %0d", err_cnt, ChkEn); end
    nvec++; if (pkt_cnt !== 16'd0) begin nmis++; $display("FAIL midrst_pkt: got %0d want 0", pkt_cnt); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_framing();
    test_truncation();
    test_length();
    test_reset_mid_packet();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule

// File: doc/merge_sink.md
# merge_sink

Synthesizable receiver for the merge network's root local output port. It accepts the merged flit stream over the valid/ready handshake, parses head/body/tail framing and strips head flits. It tags payload flits with source ID and start/end-of-packet markers, buffers them in a FIFO and presents them to the local consumer. It replaces the bench-only monitor at the destination tile and counts completed and malformed packets.

## Interface
- `DW`, 32, flit width; must match the network data width.
- `SRC_W`, 4, source-ID field width.
- `LEN_W`, 8, head-flit length field width (payload flits per packet).
- `DEPTH`, 8, FIFO entries; power of two, minimum 2.

- `clk` input 1: single clock; all logic is rising-edge.
- `rst` input 1: synchronous, active-high reset.
- `valid_i` input 1: flit valid from the network local output.
- `data_i` input DW: flit from the network.
- `ready_o` output 1: flit accepted when `valid_i && ready_o` at a rising edge.
- `out_valid` output 1: FIFO head is valid.
- `out_ready` input 1: consumer pops when `out_valid && out_ready`.
- `out_data` output DW-2: payload, which is `data_i[DW-3:0]` of a body or tail flit.
- `out_src` output SRC_W: source ID latched from the packet's head.
- `out_sop` output 1: first payload flit of the packet.
- `out_eop` output 1: last payload flit of the packet (the tail flit).
- `pkt_cnt` output 16: completed packets; wraps at 2^16.
- `err_cnt` output 8: framing errors; saturates at 255.

## Operation
- **Flit type** is `data_i[DW-1:DW-2]`:
  - 01 = head, with `src = data_i[DW-3 -: SRC_W]` and `len = data_i[LEN_W-1:0]`.
  - 00 = body.
  - 10 = tail.
  - 11 = reserved.
- **FSM states** are IDLE and PAYLOAD. A register `rem` (LEN_W bits) counts payload flits still expected.
- **IDLE:**
  - Head with `len >= 1`: latch `src`, set `rem = len`, set `first = 1`, go to PAYLOAD. Head flits are never pushed into the FIFO.
  - Head with `len == 0`: error, stay in IDLE.
  - Body, tail or reserved: error, flit dropped.
- **PAYLOAD:**
  - Body: push `{sop=first, eop=0}`, clear `first`, decrement `rem`.
  - Tail: push `{sop=first, eop=1}`, increment `pkt_cnt`, go to IDLE.
  - Head: error (truncated packet). No FIFO entry is written for the lost packet's end. The new head is processed as in IDLE.
  - Reserved: error, flit dropped, state unchanged.
- **Length check:**
  - A tail arriving with `rem != 1` is an error, but the packet still closes normally.
  - A body arriving with `rem == 1` is an error. The flit is still pushed and `rem` saturates at 0.
- **`ready_o`** is `!rst && !full`. It is derived from registered state only and never depends on `valid_i`. Drops and head flits also require `ready_o`.
- **FIFO** is first-word-fallthrough. A push and a pop in the same cycle are allowed when the FIFO is not full; the occupancy is unchanged. When full, `ready_o` is 0, so no push can coincide.
- **`err_cnt`** increments by 1 per erroneous accepted flit. At most one error is counted per flit.

## Timing
- **Reset values:** `ready_o=0`, `out_valid=0`, `out_data/out_src/out_sop/out_eop=0`, `pkt_cnt=0`, `err_cnt=0`, FSM in IDLE, FIFO empty, `rem=0`.
- **Latency:** a payload flit accepted at edge N drives `out_valid=1` and its fields from edge N (visible in cycle N+1).
- **Backpressure:** when a pop occurs at edge N from a full FIFO, `ready_o` returns to 1 after edge N.
- **`pkt_cnt`** updates at the edge that accepts the tail flit.
- **`err_cnt`** updates at the edge that accepts the offending flit.
- **Reset mid-packet:** the partial packet is discarded, FIFO contents are lost, and the first flit after reset is parsed in IDLE.
- **Output hold:** `out_*` stay stable while `out_valid && !out_ready`.

## Configuration
- **`MERGE_SINK_CHECK_EN` defined:** full framing and length checking as specified above. `err_cnt` is live.
- **`MERGE_SINK_CHECK_EN` undefined:**
  - The `rem` register and length checks are removed.
  - Only the tail closes a packet, and `len` is ignored; a head with `len == 0` is therefore accepted and enters PAYLOAD.
  - Framing violations (non-head in IDLE, head in PAYLOAD, reserved type) still drop or restart flits as specified but are not counted.
  - `err_cnt` is tied to 0.

## Test plan
- **Basic packet:** head(src=3, len=3), body 0x11, body 0x22, tail 0x33, with `out_ready=1` -> three outputs with src=3, sop/eop = 10, 00, 01; `pkt_cnt=1`; `err_cnt=0`; each output appears one cycle after acceptance.
- **Backpressure:** `out_ready=0`; stream 2 packets of len=5 (10 payload flits) with DEPTH=8 -> `ready_o` falls after the 8th push; release `out_ready` -> all 10 flits delivered in order; `ready_o` reasserts one cycle after the first pop.
- **Framing errors:** body in IDLE, then reserved type, then head(len=0) -> `err_cnt=3`, no FIFO pushes, `pkt_cnt=0`.
- **Truncation:** head(src=1, len=4), body 0xA, head(src=2, len=1), tail 0xB -> outputs are (0xA, src=1, sop=1, eop=0) and (0xB, src=2, sop=1, eop=1); `err_cnt=1`; `pkt_cnt=1`.
- **Length mismatch with `MERGE_SINK_CHECK_EN` defined:** head(len=3), tail -> `err_cnt=1`, `pkt_cnt=1`.
- **Length mismatch with `MERGE_SINK_CHECK_EN` undefined:** head(len=3), tail -> `err_cnt=0`, `pkt_cnt=1`.
- **Reset mid-packet:** assert `rst` for one cycle after the head and one body; then send a tail -> all outputs return to reset values; the tail is dropped; `err_cnt=1` with the check enabled, 0 without.
